// File: rtl/dshot_frame_decoder.sv
// DShot receiver front end: synchronizes the pin, times each high pulse,
// assembles 16-bit frames, checks the CRC and publishes throttle/telemetry/speed.
module dshot_frame_decoder #(
   parameter int unsigned BIT_THRESH = 60,
   parameter int unsigned MIN_HIGH   = 10,
   parameter int unsigned MAX_HIGH   = 100,
   parameter int unsigned FRAME_GAP  = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dshot_in,
   output logic [10:0] throttle,
   output logic        telemetry,
   output logic [7:0]  speed,
   output logic        frame_valid,
   output logic        crc_error,
   output logic        frame_error,
   output logic [7:0]  err_count
);

   localparam int unsigned HW      = $clog2(MAX_HIGH + 2);
   localparam int unsigned LW      = $clog2(FRAME_GAP + 1);
   localparam int unsigned FW      = 16;
   localparam int unsigned BW      = 5;
   localparam int unsigned TW      = 11;
   localparam int unsigned ARM_THR = 48;

   localparam logic [HW-1:0] H_SAT = HW'(MAX_HIGH + 1);
   localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
   localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
   localparam logic [HW-1:0] H_BIT = HW'(BIT_THRESH);
   localparam logic [LW-1:0] L_GAP = LW'(FRAME_GAP);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, LOW} state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q, prev_q;
   logic [HW-1:0]   high_cnt_q, high_cnt_d;
   logic [LW-1:0]   low_cnt_q, low_cnt_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FW-1:0]   shift_q, shift_d;
   logic            check_q, check_d;
   logic [TW-1:0]   throttle_q, throttle_d;
   logic            telem_q, telem_d;
   logic [7:0]      speed_q, speed_d;
   logic            valid_q, valid_d;
   logic            crc_err_q, crc_err_d;
   logic            frame_err_q, frame_err_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic            rise_c, fall_c, short_c, long_c, pulse_ok_c, pulse_bad_c, gap_hit_c, partial_c;
   logic [HW-1:0]   high_nx_c;
   logic [LW-1:0]   low_nx_c;
   logic [11:0]     data_c;
   logic [3:0]      crc_c;
   logic [TW-1:0]   thr_c, armed_c;
   logic [7:0]      speed_new_c;

   // Pulse timing and frame-check decode shared by both combinational processes
   always_comb begin
      rise_c      = sync2_q & ~prev_q;
      fall_c      = ~sync2_q & prev_q;
      high_nx_c   = (high_cnt_q >= H_SAT) ? high_cnt_q : high_cnt_q + HW'(1);
      low_nx_c    = (low_cnt_q >= L_GAP) ? low_cnt_q : low_cnt_q + LW'(1);
      short_c     = high_nx_c < H_MIN;
      long_c      = high_nx_c > H_MAX;
      pulse_ok_c  = fall_c & ~short_c & ~long_c;
      pulse_bad_c = (fall_c & short_c) | long_c;
      gap_hit_c   = low_nx_c >= L_GAP;
      partial_c   = (bit_cnt_q != BW'(0)) && (bit_cnt_q < BW'(FW));
      data_c      = shift_q[15:4];
      crc_c       = data_c[3:0] ^ data_c[7:4] ^ data_c[11:8];
      thr_c       = shift_q[15:5];
      armed_c     = thr_c - TW'(ARM_THR);
      speed_new_c = (thr_c < TW'(ARM_THR)) ? 8'd0 : armed_c[10:3];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= WAIT_LOW;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LOW: if (!sync2_q && gap_hit_c) state_d = IDLE;
         IDLE:     if (rise_c) state_d = HIGH;
         HIGH: begin
            if (pulse_bad_c)     state_d = WAIT_LOW;
            else if (pulse_ok_c) state_d = LOW;
         end
         LOW: begin
            if (rise_c)         state_d = HIGH;
            else if (gap_hit_c) state_d = IDLE;
         end
         default: state_d = WAIT_LOW;
      endcase
   end

   always_comb begin
      high_cnt_d  = high_cnt_q;
      low_cnt_d   = low_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      check_d     = 1'b0;
      throttle_d  = throttle_q;
      telem_d     = telem_q;
      speed_d     = speed_q;
      valid_d     = 1'b0;
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      case (state_q)
         WAIT_LOW: low_cnt_d = sync2_q ? '0 : low_nx_c;
         IDLE:     if (rise_c) high_cnt_d = '0;
         HIGH: begin
            high_cnt_d = high_nx_c;
            if (pulse_bad_c) begin
               frame_err_d = 1'b1;
               bit_cnt_d   = '0;
               low_cnt_d   = '0;
            end else if (pulse_ok_c) begin
               shift_d   = {shift_q[FW-2:0], high_nx_c >= H_BIT};
               bit_cnt_d = bit_cnt_q + BW'(1);
               low_cnt_d = '0;
               check_d   = (bit_cnt_q == BW'(FW - 1));
            end
         end
         LOW: begin
            low_cnt_d = low_nx_c;
            if (rise_c) begin
               high_cnt_d = '0;
            end else if (gap_hit_c) begin
               frame_err_d = partial_c;
               bit_cnt_d   = '0;
            end
         end
         default: ;
      endcase
      // Frame check runs the cycle after bit 16 lands
      if (check_q) begin
         bit_cnt_d = '0;
         if (crc_c == shift_q[3:0]) begin
            throttle_d = thr_c;
            telem_d    = shift_q[4];
            speed_d    = speed_new_c;
            valid_d    = 1'b1;
         end else begin
            crc_err_d = 1'b1;
         end
      end
      if ((crc_err_d || frame_err_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         high_cnt_q  <= '0;
         low_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         check_q     <= 1'b0;
         throttle_q  <= '0;
         telem_q     <= 1'b0;
         speed_q     <= '0;
         valid_q     <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         sync1_q     <= dshot_in;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         high_cnt_q  <= high_cnt_d;
         low_cnt_q   <= low_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         check_q     <= check_d;
         throttle_q  <= throttle_d;
         telem_q     <= telem_d;
         speed_q     <= speed_d;
         valid_q     <= valid_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign throttle    = throttle_q;
   assign telemetry   = telem_q;
   assign speed       = speed_q;
   assign frame_valid = valid_q;
   assign crc_error   = crc_err_q;
   assign frame_error = frame_err_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_dshot_frame_decoder.sv
// Bench for dshot_frame_decoder: table of frames plus hand-built timing and
// reset sequences; every output pulse is matched against a queue of expectations.
module tb_dshot_frame_decoder;

   localparam logic [2:0] EV_VALID = 3'b001;
   localparam logic [2:0] EV_CRC   = 3'b010;
   localparam logic [2:0] EV_FERR  = 3'b100;

   typedef struct {
      logic [2:0] ev;
      int         thr;
      int         tel;
      int         spd;
   } exp_t;

   typedef struct {
      logic [15:0] word;
      bit          fast;
      logic [2:0]  ev;
      int          thr;
      int          tel;
      int          spd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dshot_in;
   logic [10:0] throttle;
   logic        telemetry;
   logic [7:0]  speed;
   logic        frame_valid;
   logic        crc_error;
   logic        frame_error;
   logic [7:0]  err_count;

   int   checks   = 0;
   int   failures = 0;
   int   exp_err  = 0;
   exp_t q[$];

   dshot_frame_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .dshot_in    (dshot_in),
      .throttle    (throttle),
      .telemetry   (telemetry),
      .speed       (speed),
      .frame_valid (frame_valid),
      .crc_error   (crc_error),
      .frame_error (frame_error),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] ev, input int thr, input int tel, input int spd);
      exp_t e;
      e.ev = ev; e.thr = thr; e.tel = tel; e.spd = spd;
      q.push_back(e);
      if (ev != EV_VALID && exp_err < 255) exp_err++;
   endtask

   task automatic hold(input logic lvl, input int n);
      dshot_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input bit fast);
      for (int i = 15; i > 15 - n; i--) begin
         if (fast) begin
            hold(1'b1, w[i] ? 61 : 11);
            hold(1'b0, 2);
         end else begin
            hold(1'b1, w[i] ? 80 : 40);
            hold(1'b0, w[i] ? 27 : 67);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
   endtask

   // Pulse monitor: every pulse must match the oldest pending expectation
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (frame_valid || crc_error || frame_error) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got pulses=%b expected none",
                     {frame_error, crc_error, frame_valid});
         end else begin
            e = q.pop_front();
            chk("event_kind", int'({frame_error, crc_error, frame_valid}), int'(e.ev));
            chk("throttle", int'(throttle), e.thr);
            chk("telemetry", int'(telemetry), e.tel);
            chk("speed", int'(speed), e.spd);
         end
      end
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{16'h82C6, 1'b0, EV_VALID, 1046, 0, 124};
      tbl[1] = '{16'hFFFF, 1'b0, EV_VALID, 2047, 1, 249};
      tbl[2] = '{16'h0000, 1'b1, EV_VALID, 0,    0, 0};
      tbl[3] = '{16'h82C6, 1'b1, EV_VALID, 1046, 0, 124};
      tbl[4] = '{16'h82C7, 1'b1, EV_CRC,   1046, 0, 124};
      tbl[5] = '{16'h00BB, 1'b1, EV_VALID, 5,    1, 0};
      tbl[6] = '{16'h0606, 1'b1, EV_VALID, 48,   0, 0};
      tbl[7] = '{16'h0707, 1'b1, EV_VALID, 56,   0, 1};

      rst = 1'b1;
      dshot_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_throttle", int'(throttle), 0);
      chk("reset_telemetry", int'(telemetry), 0);
      chk("reset_speed", int'(speed), 0);
      chk("reset_err_count", int'(err_count), 0);
      chk("reset_pulses", int'({frame_error, crc_error, frame_valid}), 0);
      rst = 1'b0;
      hold(1'b0, 250);

      for (int i = 0; i < 8; i++) begin
         push(tbl[i].ev, tbl[i].thr, tbl[i].tel, tbl[i].spd);
         send_bits(tbl[i].word, 16, tbl[i].fast);
         hold(1'b0, 50);
         drain();
         chk("table_err_count", int'(err_count), exp_err);
      end

      // Truncated frame aborts on the low gap, then a good frame recovers
      push(EV_FERR, 56, 0, 1);
      send_bits(16'h82C6, 9, 1'b0);
      hold(1'b0, 250);
      drain();
      chk("trunc_err_count", int'(err_count), exp_err);
      push(EV_VALID, 1046, 0, 124);
      send_bits(16'h82C6, 16, 1'b0);
      hold(1'b0, 50);
      drain();

      // Short glitch mid-frame
      push(EV_FERR, 1046, 0, 124);
      send_bits(16'h82C6, 4, 1'b0);
      hold(1'b1, 5);
      hold(1'b0, 20);
      chk("glitch_immediate", q.size(), 0);
      hold(1'b0, 250);
      drain();
      chk("glitch_err_count", int'(err_count), exp_err);

      // Overlong high pulse errors while still high, just past MAX_HIGH
      push(EV_FERR, 1046, 0, 124);
      hold(1'b1, 100);
      chk("long_not_yet", q.size(), 1);
      hold(1'b1, 6);
      chk("long_at_limit", q.size(), 0);
      hold(1'b1, 44);
      hold(1'b0, 250);
      drain();
      chk("long_err_count", int'(err_count), exp_err);

      // Pulse-length boundaries: in-range pulses start a frame, out-of-range error at once
      push(EV_FERR, 1046, 0, 124);
      hold(1'b1, 11);
      hold(1'b0, 20);
      chk("min_side_accepted", q.size(), 1);
      hold(1'b0, 250);
      drain();
      push(EV_FERR, 1046, 0, 124);
      hold(1'b1, 9);
      hold(1'b0, 20);
      chk("min_side_rejected", q.size(), 0);
      hold(1'b0, 250);
      push(EV_FERR, 1046, 0, 124);
      hold(1'b1, 99);
      hold(1'b0, 20);
      chk("max_side_accepted", q.size(), 1);
      hold(1'b0, 250);
      drain();
      push(EV_FERR, 1046, 0, 124);
      hold(1'b1, 102);
      hold(1'b0, 20);
      chk("max_side_rejected", q.size(), 0);
      hold(1'b0, 250);
      drain();

      push(EV_VALID, 1046, 0, 124);
      send_bits(16'h82C6, 16, 1'b0);
      hold(1'b0, 50);
      drain();
      chk("timing_err_count", int'(err_count), exp_err);

      // Reset mid-frame
      send_bits(16'h82C6, 8, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_err = 0;
      chk("midrst_throttle", int'(throttle), 0);
      chk("midrst_telemetry", int'(telemetry), 0);
      chk("midrst_speed", int'(speed), 0);
      chk("midrst_err_count", int'(err_count), 0);
      hold(1'b0, 20);
      send_bits(16'h82C6, 16, 1'b1);
      hold(1'b0, 250);
      chk("no_decode_before_gap", int'(throttle), 0);
      push(EV_VALID, 1046, 0, 124);
      send_bits(16'h82C6, 16, 1'b0);
      hold(1'b0, 50);
      drain();

      // Error counter saturation
      for (int i = 0; i < 258; i++) begin
         push(EV_CRC, 1046, 0, 124);
         send_bits(16'h0001, 16, 1'b1);
         hold(1'b0, 4);
         drain();
      end
      chk("err_count_saturated", int'(err_count), 255);

      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
